round_sequencer: RTL

//  Sequences one match of the cat/dog/chicken game: latches P1, then P2, choice from the shared SW[2:0],

---
 rtl/round_sequencer_if.sv | 25 ++
 rtl/round_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/round_sequencer_if.sv
// Signal bundle between the round sequencer and its surroundings: user inputs,
// the draw-logic handshake, and the score/status outputs.
interface round_sequencer_if;
   logic       soft_clear;
   logic       confirm;
   logic [2:0] choice;
   logic       draw_done;
   logic       draw_start;
   logic [3:0] scenario;
   logic [1:0] round_winner;
   logic [3:0] player1;
   logic [3:0] player2;
   logic [2:0] phase;
   logic       match_over;

   modport master (
      output soft_clear, confirm, choice, draw_done,
      input  draw_start, scenario, round_winner, player1, player2, phase, match_over
   );

   modport slave (
      input  soft_clear, confirm, choice, draw_done,
      output draw_start, scenario, round_winner, player1, player2, phase, match_over
   );
endinterface

// File: rtl/round_sequencer.sv
// Match sequencer for the cat/dog/chicken game: latches both players' choices,
// resolves the round, hands the scenario to the draw logic and keeps score.
module round_sequencer #(
   parameter int WIN_SCORE   = 5,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int HOLD_W      = 26
) (
   input  logic               clk,
   input  logic               resetn,
   round_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      P1_WAIT   = 3'd0,
      P2_WAIT   = 3'd1,
      RESOLVE   = 3'd2,
      DRAW      = 3'd3,
      SCORE     = 3'd4,
      HOLD      = 3'd5,
      GAME_OVER = 3'd6
   } state_e;

   localparam logic [3:0]        WIN_Q  = 4'(WIN_SCORE);
   localparam logic [HOLD_W-1:0] HOLD_Q = HOLD_W'(HOLD_CYCLES);

   state_e            state_q;
   logic              confirm_q;
   logic              conf_edge_q;
   logic [1:0]        p1_q;
   logic [1:0]        p2_q;
   logic [HOLD_W-1:0] hold_q;
   logic [3:0]        scenario_q;
   logic [1:0]        round_winner_q;
   logic              draw_start_q;
   logic [3:0]        player1_q;
   logic [3:0]        player2_q;
   logic              match_over_q;

   logic [3:0]        scenario_d;
   logic [1:0]        round_winner_d;

   // Anything that is not exactly one-hot counts as cat.
   function automatic logic [1:0] choice_idx(input logic [2:0] c);
      case (c)
         3'b010:  return 2'd1;
         3'b100:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      scenario_d     = ({2'b00, p1_q} * 4'd3) + {2'b00, p2_q};
      round_winner_d = 2'b10;
      if (p1_q == p2_q) begin
         round_winner_d = 2'b11;
      end else begin
         case ({p1_q, p2_q})
            {2'd1, 2'd0},
            {2'd0, 2'd2},
            {2'd2, 2'd1}: round_winner_d = 2'b01;
            default:      round_winner_d = 2'b10;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= P1_WAIT;
         // A confirm key held through reset must be released before it counts.
         confirm_q      <= 1'b1;
         conf_edge_q    <= 1'b0;
         p1_q           <= 2'd0;
         p2_q           <= 2'd0;
         hold_q         <= '0;
         scenario_q     <= 4'd0;
         round_winner_q <= 2'b00;
         draw_start_q   <= 1'b0;
         player1_q      <= 4'd0;
         player2_q      <= 4'd0;
         match_over_q   <= 1'b0;
      end else begin
         confirm_q    <= bus.confirm;
         conf_edge_q  <= bus.confirm & ~confirm_q;
         draw_start_q <= 1'b0;

         if (bus.soft_clear) begin
            state_q        <= P1_WAIT;
            hold_q         <= '0;
            round_winner_q <= 2'b00;
            player1_q      <= 4'd0;
            player2_q      <= 4'd0;
            match_over_q   <= 1'b0;
         end else begin
            case (state_q)
               P1_WAIT: if (conf_edge_q) begin
                  p1_q    <= choice_idx(bus.choice);
                  state_q <= P2_WAIT;
               end
               P2_WAIT: if (conf_edge_q) begin
                  p2_q    <= choice_idx(bus.choice);
                  state_q <= RESOLVE;
               end
               RESOLVE: begin
                  scenario_q     <= scenario_d;
                  round_winner_q <= round_winner_d;
                  draw_start_q   <= 1'b1;
                  state_q        <= DRAW;
               end
               // The first DRAW cycle is the draw_start cycle, so a coincident draw_done is taken.
               DRAW: if (bus.draw_done) state_q <= SCORE;
               SCORE: begin
                  if (round_winner_q == 2'b01 && player1_q < WIN_Q) player1_q <= player1_q + 4'd1;
                  if (round_winner_q == 2'b10 && player2_q < WIN_Q) player2_q <= player2_q + 4'd1;
                  hold_q  <= HOLD_Q;
                  state_q <= HOLD;
               end
               HOLD: begin
                  if (hold_q <= HOLD_W'(1)) begin
                     hold_q <= '0;
                     if (player1_q == WIN_Q || player2_q == WIN_Q) begin
                        match_over_q <= 1'b1;
                        state_q      <= GAME_OVER;
                     end else begin
                        round_winner_q <= 2'b00;
                        state_q        <= P1_WAIT;
                     end
                  end else begin
                     hold_q <= hold_q - HOLD_W'(1);
                  end
               end
               GAME_OVER: if (conf_edge_q) begin
                  player1_q      <= 4'd0;
                  player2_q      <= 4'd0;
                  round_winner_q <= 2'b00;
                  match_over_q   <= 1'b0;
                  state_q        <= P1_WAIT;
               end
               default: state_q <= P1_WAIT;
            endcase
         end
      end
   end

   assign bus.draw_start   = draw_start_q;
   assign bus.scenario     = scenario_q;
   assign bus.round_winner = round_winner_q;
   assign bus.player1      = player1_q;
   assign bus.player2      = player2_q;
   assign bus.phase        = state_q;
   assign bus.match_over   = match_over_q;

endmodule
